// File: rtl/mult_sched_2ch.sv
// Two-channel scheduler around one sequential shift-add signed multiplier.
// Round-robin grant in IDLE, WIDTH add/shift steps, then a one-cycle DONE pulse.
//
// state  | meaning
// IDLE   | waiting for Req0/Req1; captures the granted channel's operands
// ADD    | one shift-add step per cycle, counter 0..WIDTH-1
// DONE   | M holds the owner's product; owner's Done pulse
module mult_sched_2ch #(
  parameter int WIDTH = 4
) (
  input  logic               Clk,
  input  logic               Resetn,
  input  logic               Req0,
  input  logic [WIDTH-1:0]   X0,
  input  logic [WIDTH-1:0]   Y0,
  input  logic               Req1,
  input  logic [WIDTH-1:0]   X1,
  input  logic [WIDTH-1:0]   Y1,
  output logic               Ack0,
  output logic               Ack1,
  output logic               Done0,
  output logic               Done1,
  output logic [2*WIDTH-1:0] M,
  output logic               Busy
);

  localparam int PW = 2 * WIDTH;
  localparam int MW = WIDTH + 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   x_mag;
  logic [MW-1:0]   y_mag;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            neg;
  logic            owner;
  logic            last_ch;

  logic             req_any;
  logic             grant_ch;
  logic [WIDTH-1:0] sel_x;
  logic [WIDTH-1:0] sel_y;
  logic [PW-1:0]    acc_step;
  logic [PW-1:0]    m_val;
  logic             last_step;

  // Magnitude needs one extra bit so the most-negative operand stays exact.
  function automatic logic [MW-1:0] mag(input logic [WIDTH-1:0] v);
    logic [MW-1:0] ext;
    ext = {v[WIDTH-1], v};
    return ext[MW-1] ? (~ext + MW'(1)) : ext;
  endfunction

  assign req_any   = Req0 | Req1;
  assign grant_ch  = (Req0 && (!Req1 || last_ch)) ? 1'b0 : 1'b1;
  assign sel_x     = grant_ch ? X1 : X0;
  assign sel_y     = grant_ch ? Y1 : Y0;
  assign acc_step  = acc + (y_mag[0] ? x_mag : '0);
  assign m_val     = neg ? (-acc_step) : acc_step;
  assign last_step = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_any) state_nxt = S_ADD;
      S_ADD:   if (last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Ack0  = 1'b0;
    Ack1  = 1'b0;
    Done0 = 1'b0;
    Done1 = 1'b0;
    Busy  = (state != S_IDLE);
    if (state == S_ADD && cnt == '0) begin
      Ack0 = !owner;
      Ack1 = owner;
    end
    if (state == S_DONE) begin
      Done0 = !owner;
      Done1 = owner;
    end
  end

  // last_ch resets to 1 so that channel 0 wins the first contested grant.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      x_mag   <= '0;
      y_mag   <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      owner   <= 1'b0;
      last_ch <= 1'b1;
      M       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            x_mag   <= PW'(mag(sel_x));
            y_mag   <= mag(sel_y);
            acc     <= '0;
            cnt     <= '0;
            neg     <= sel_x[WIDTH-1] ^ sel_y[WIDTH-1];
            owner   <= grant_ch;
            last_ch <= grant_ch;
          end
        end
        S_ADD: begin
          acc   <= acc_step;
          x_mag <= x_mag << 1;
          y_mag <= y_mag >> 1;
          cnt   <= cnt + CW'(1);
          if (last_step) M <= m_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched_2ch.sv
// Self-checking bench for mult_sched_2ch: directed scenarios plus random jobs
// compared against an arithmetic product / round-robin reference model.
module tb_mult_sched_2ch;
  localparam int W = 4;

  logic           Clk = 1'b0;
  logic           Resetn;
  logic           Req0, Req1;
  logic [W-1:0]   X0, Y0, X1, Y1;
  logic           Ack0, Ack1, Done0, Done1, Busy;
  logic [2*W-1:0] M;

  int checks   = 0;
  int failures = 0;
  bit exp_last = 1'b1;  // channel served last, as the model sees it

  always #5 Clk = ~Clk;

  mult_sched_2ch #(.WIDTH(W)) dut (
    .Clk(Clk), .Resetn(Resetn),
    .Req0(Req0), .X0(X0), .Y0(Y0),
    .Req1(Req1), .X1(X1), .Y1(Y1),
    .Ack0(Ack0), .Ack1(Ack1), .Done0(Done0), .Done1(Done1),
    .M(M), .Busy(Busy)
  );

  function automatic logic [7:0] ref_prod(input logic [3:0] x, input logic [3:0] y);
    int p;
    p = $signed(x) * $signed(y);
    return p[7:0];
  endfunction

  function automatic bit ref_grant(input bit r0, input bit r1);
    if (r0 && r1) return !exp_last;
    return r0 ? 1'b0 : 1'b1;
  endfunction

  // One complete job from the IDLE negedge through return to IDLE.
  task automatic run_job(input bit r0, input bit r1,
                         input logic [3:0] x0, input logic [3:0] y0,
                         input logic [3:0] x1, input logic [3:0] y1,
                         input string tag);
    bit         g;
    logic [7:0] exp_m;
    logic [1:0] onehot;
    g      = ref_grant(r0, r1);
    exp_m  = g ? ref_prod(x1, y1) : ref_prod(x0, y0);
    onehot = g ? 2'b10 : 2'b01;
    Req0 = r0; Req1 = r1; X0 = x0; Y0 = y0; X1 = x1; Y1 = y1;
    @(posedge Clk); @(negedge Clk);
    checks++;
    if ({Ack1, Ack0} !== onehot || Busy !== 1'b1) begin
      failures++;
      $display("FAIL %s ack: got ack=%b busy=%b, expected ack=%b busy=1", tag, {Ack1, Ack0}, Busy, onehot);
    end
    exp_last = g;
    if (g) begin Req1 = 1'b0; X1 = 4'($urandom); Y1 = 4'($urandom); end
    else   begin Req0 = 1'b0; X0 = 4'($urandom); Y0 = 4'($urandom); end
    for (int i = 1; i < W; i++) begin
      @(negedge Clk);
      checks++;
      if ({Ack1, Ack0, Done1, Done0} !== 4'b0 || Busy !== 1'b1) begin
        failures++;
        $display("FAIL %s step%0d: got ack/done=%b busy=%b, expected 0000 busy=1", tag, i, {Ack1, Ack0, Done1, Done0}, Busy);
      end
    end
    @(negedge Clk);
    checks++;
    if ({Done1, Done0} !== onehot || M !== exp_m) begin
      failures++;
      $display("FAIL %s done: got done=%b M=%h, expected done=%b M=%h", tag, {Done1, Done0}, M, onehot, exp_m);
    end
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || {Done1, Done0} !== 2'b0) begin
      failures++;
      $display("FAIL %s idle: got busy=%b done=%b, expected busy=0 done=00", tag, Busy, {Done1, Done0});
    end
    Req0 = 1'b0; Req1 = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; Req0 = 0; Req1 = 0; X0 = 0; Y0 = 0; X1 = 0; Y1 = 0;
    #12;
    checks++;
    if ({Ack0, Ack1, Done0, Done1, Busy} !== 5'b0 || M !== 8'h00) begin
      failures++;
      $display("FAIL reset: got ack/done/busy=%b M=%h, expected 00000 M=00", {Ack0, Ack1, Done0, Done1, Busy}, M);
    end
    @(negedge Clk); Resetn = 1'b1; exp_last = 1'b1;
  endtask

  task automatic test_ch0_basic();
    run_job(1, 0, 4'd3, 4'd5, 4'd0, 4'd0, "ch0_3x5");
  endtask

  task automatic test_signed_products();
    run_job(0, 1, 4'd0, 4'd0, 4'h8, 4'h8, "ch1_m8xm8");
    run_job(1, 0, 4'h8, 4'd7, 4'd0, 4'd0, "ch0_m8x7");
    run_job(1, 0, 4'd5, 4'hD, 4'd0, 4'd0, "ch0_5xm3");
    run_job(1, 0, 4'd0, 4'hF, 4'd0, 4'd0, "ch0_0xm1");
    run_job(1, 0, 4'hD, 4'd6, 4'd0, 4'd0, "ch0_operand_change");
  endtask

  task automatic test_back_to_back();
    @(negedge Clk); Resetn = 1'b0;
    #1;
    exp_last = 1'b1;
    @(negedge Clk); Resetn = 1'b1;
    run_job(1, 1, 4'd2, 4'hC, 4'hB, 4'd3, "b2b_first");
    run_job(0, 1, 4'd0, 4'd0, 4'hB, 4'd3, "b2b_second");
  endtask

  task automatic test_hold();
    Req0 = 1'b1; X0 = 4'd2; Y0 = 4'd3;
    for (int k = 0; k < 3; k++) begin
      @(posedge Clk); @(negedge Clk);
      checks++;
      if (Ack0 !== 1'b1 || Ack1 !== 1'b0) begin
        failures++;
        $display("FAIL hold_ack%0d: got ack0=%b ack1=%b, expected ack0=1 ack1=0", k, Ack0, Ack1);
      end
      if (k == 2) begin Req1 = 1'b1; X1 = 4'd3; Y1 = 4'hE; end
      repeat (W) @(negedge Clk);
      checks++;
      if (Done0 !== 1'b1 || M !== 8'h06) begin
        failures++;
        $display("FAIL hold_done%0d: got done0=%b M=%h, expected done0=1 M=06", k, Done0, M);
      end
      @(negedge Clk);
    end
    @(posedge Clk); @(negedge Clk);
    checks++;
    if (Ack1 !== 1'b1 || Ack0 !== 1'b0) begin
      failures++;
      $display("FAIL hold_ch1_grant: got ack0=%b ack1=%b, expected ack0=0 ack1=1", Ack0, Ack1);
    end
    Req1 = 1'b0; Req0 = 1'b0;
    repeat (W) @(negedge Clk);
    checks++;
    if (Done1 !== 1'b1 || M !== 8'hFA) begin
      failures++;
      $display("FAIL hold_ch1_done: got done1=%b M=%h, expected done1=1 M=fa", Done1, M);
    end
    @(negedge Clk);
    exp_last = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    Req0 = 1'b1; X0 = 4'd3; Y0 = 4'd3;
    @(posedge Clk); @(negedge Clk);
    Req0 = 1'b0;
    repeat (2) @(negedge Clk);
    Resetn = 1'b0;
    #1;
    checks++;
    if ({Ack0, Ack1, Done0, Done1, Busy} !== 5'b0 || M !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid: got ack/done/busy=%b M=%h, expected 00000 M=00", {Ack0, Ack1, Done0, Done1, Busy}, M);
    end
    exp_last = 1'b1;
    @(negedge Clk); Resetn = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (Done0 || Done1 || Busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort: got activity=%b after reset, expected 0", saw_done);
    end
    run_job(1, 1, 4'd7, 4'd7, 4'd5, 4'd5, "reset_recover");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int r;
      r = int'($urandom_range(1, 3));
      run_job(r[0], r[1], 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_ch0_basic();
    test_signed_products();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
